bellek_erisim: RTL and testbench
================================

BELLEK_ERISIM -- requirements
Module: bellek_erisim

Interface
REQ-001 Parameter ZAMAN_ASIMI, default 16, max cycles in BEKLE waiting for load data before abort.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 amb_gecerli_i  input  1  ALU-stage result valid this cycle.
REQ-005 amb_sonuc_i  input  32  ALU result; effective address for memory ops.
REQ-006 yazmac_degeri2_i  input  32  store data (rs2).
REQ-007 bellek_islem_i  input  4  [3]=memory op, [2]=store(1)/load(0), [1:0]=size 00 byte/01 half/10 word; 11 reserved.
REQ-008 isaretsiz_i  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 hedef_yazmac_i  input  5  destination register index.
REQ-010 bellek_istek_o  output  1  memory request valid.
REQ-011 bellek_yaz_o  output  1  request is a write.
REQ-012 bellek_adres_o  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 bellek_veri_o  output  32  write data, lane-replicated.
REQ-014 bellek_maske_o  output  4  byte enables.
REQ-015 bellek_hazir_i  input  1  memory accepts request this cycle.
REQ-016 bellek_gecerli_i  input  1  read data valid.
REQ-017 bellek_veri_i  input  32  read data word.
REQ-018 gy_gecerli_o, gy_veri_o[31:0], gy_yazmac_o[4:0]  output  writeback valid, data, register index.
REQ-019 durdur_o  output  1  upstream stall; high while state != BOSTA.
REQ-020 hizasiz_o, zaman_asimi_o  output  1  one-cycle misalignment / timeout error pulses.

Function
REQ-021 FSM states BOSTA, ISTEK, BEKLE; inputs sampled only in BOSTA, ignored (upstream holds) while durdur_o=1.
REQ-022 Non-memory op (bellek_islem_i[3]=0) in BOSTA: next cycle gy_gecerli_o=1, gy_veri_o=amb_sonuc_i, gy_yazmac_o=hedef_yazmac_i; state stays BOSTA.
REQ-023 gy_gecerli_o SHALL be forced 0 whenever the destination index is 0.
REQ-024 Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size 11 -> no request, hizasiz_o=1 next cycle, no writeback, stay BOSTA.
REQ-025 Aligned memory op in BOSTA: capture address, data, size, sign, rd; go ISTEK; bellek_istek_o=1 from next cycle, held stable until bellek_hazir_i=1.
REQ-026 Store masks: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; bellek_veri_o = byte x4 / half x2 / word replicated.
REQ-027 Load masks identical to store; bellek_veri_o=0 for loads.
REQ-028 ISTEK with bellek_hazir_i=1: store -> BOSTA (no writeback); load -> BEKLE; bellek_istek_o drops next cycle.
REQ-029 BEKLE with bellek_gecerli_i=1: select byte/half by captured addr[1:0], extend per isaretsiz, present on gy_veri_o with gy_gecerli_o=1 next cycle; go BOSTA.
REQ-030 BEKLE counter counts cycles from entry; reaching ZAMAN_ASIMI without bellek_gecerli_i -> zaman_asimi_o=1 one cycle, no writeback, go BOSTA.
REQ-031 bellek_gecerli_i outside BEKLE SHALL be ignored.
REQ-032 bellek_gecerli_i and timeout in same cycle: data wins, no timeout pulse.
REQ-033 gy_gecerli_o, hizasiz_o, zaman_asimi_o are single-cycle pulses; gy_veri_o/gy_yazmac_o hold last value otherwise.

Reset
REQ-034 rst_i=1 at an edge: state BOSTA, counter 0, all outputs 0, regardless of state; in-flight request abandoned, late bellek_gecerli_i ignored.

Verification
REQ-035 ADD result 0x0000_1234, rd=5 -> next cycle gy_gecerli_o=1, gy_veri_o=0x0000_1234, gy_yazmac_o=5, durdur_o=0.
REQ-036 SB addr 0x1003, rs2=0xAABB_CCDD, hazir after 2 cycles -> bellek_adres_o=0x1000, maske=4'b1000, veri=0xDDDD_DDDD, no writeback.
REQ-037 LH signed addr 0x2002, read word 0x8001_7FFF -> gy_veri_o=0xFFFF_8001; same with isaretsiz_i=1 -> 0x0000_8001.
REQ-038 LW addr 0x3001 -> hizasiz_o=1 one cycle, bellek_istek_o never asserted, durdur_o stays 0.
REQ-039 LW accepted, no bellek_gecerli_i for 16 cycles -> zaman_asimi_o=1, state BOSTA, gy_gecerli_o=0.
REQ-040 rst_i=1 while in BEKLE -> next cycle all outputs 0, durdur_o=0; bellek_gecerli_i=1 afterwards yields no writeback.

Source files
------------

// File: rtl/bellek_erisim.sv
// Load/store unit: takes one ALU-stage op per idle cycle. Non-memory results go
// straight to writeback; aligned memory ops are issued as a single request and,
// for loads, the returned word is lane-selected and extended before writeback.
module bellek_erisim #(
  parameter int ZAMAN_ASIMI = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        amb_gecerli_i,
  input  logic [31:0] amb_sonuc_i,
  input  logic [31:0] yazmac_degeri2_i,
  input  logic [3:0]  bellek_islem_i,
  input  logic        isaretsiz_i,
  input  logic [4:0]  hedef_yazmac_i,
  output logic        bellek_istek_o,
  output logic        bellek_yaz_o,
  output logic [31:0] bellek_adres_o,
  output logic [31:0] bellek_veri_o,
  output logic [3:0]  bellek_maske_o,
  input  logic        bellek_hazir_i,
  input  logic        bellek_gecerli_i,
  input  logic [31:0] bellek_veri_i,
  output logic        gy_gecerli_o,
  output logic [31:0] gy_veri_o,
  output logic [4:0]  gy_yazmac_o,
  output logic        durdur_o,
  output logic        hizasiz_o,
  output logic        zaman_asimi_o
);
  localparam int SAYAC_W = $clog2(ZAMAN_ASIMI + 1);

  typedef enum logic [1:0] {BOSTA = 2'd0, ISTEK = 2'd1, BEKLE = 2'd2} durum_t;

  durum_t             r_durum, w_sonraki;
  logic [SAYAC_W-1:0] r_sayac;
  logic [31:0]        r_adres, r_wveri;
  logic [3:0]         r_maske;
  logic [1:0]         r_ofs, r_boyut;
  logic               r_yaz, r_isaretsiz;
  logic [4:0]         r_hedef;
  logic               r_gy_gecerli, r_hizasiz, r_zaman_asimi;
  logic [31:0]        r_gy_veri;
  logic [4:0]         r_gy_yazmac;

  logic               w_bellek_op, w_hiza_bozuk, w_hizasiz, w_kabul, w_sure_doldu;
  logic [3:0]         w_maske;
  logic [31:0]        w_wveri, w_kayik, w_yuk_veri, w_wb_veri;
  logic [4:0]         w_wb_yazmac;
  logic               w_wb, w_hiz_d, w_za_d;

  assign w_bellek_op   = amb_gecerli_i & bellek_islem_i[3];
  assign w_hizasiz     = w_bellek_op & w_hiza_bozuk;
  assign w_kabul       = (r_durum == BOSTA) & w_bellek_op & ~w_hiza_bozuk;
  // Last permitted wait cycle; a response in this same cycle still wins.
  assign w_sure_doldu  = (r_sayac == SAYAC_W'(ZAMAN_ASIMI - 1));
  // Moves the addressed byte/half down to bit 0 (half offsets are 0 or 2 here).
  assign w_kayik       = bellek_veri_i >> {r_ofs, 3'b000};

  // Alignment check, byte enables and lane-replicated store data for the incoming op
  always_comb begin
    w_hiza_bozuk = 1'b0;
    w_maske      = 4'b1111;
    w_wveri      = yazmac_degeri2_i;
    case (bellek_islem_i[1:0])
      2'b00: begin
        w_maske = 4'b0001 << amb_sonuc_i[1:0];
        w_wveri = {4{yazmac_degeri2_i[7:0]}};
      end
      2'b01: begin
        w_hiza_bozuk = amb_sonuc_i[0];
        w_maske      = 4'b0011 << amb_sonuc_i[1:0];
        w_wveri      = {2{yazmac_degeri2_i[15:0]}};
      end
      2'b10:   w_hiza_bozuk = |amb_sonuc_i[1:0];
      default: w_hiza_bozuk = 1'b1;
    endcase
    if (!bellek_islem_i[2]) w_wveri = '0;
  end

  // Lane select and sign/zero extension of returned load data
  always_comb begin
    w_yuk_veri = bellek_veri_i;
    case (r_boyut)
      2'b00:   w_yuk_veri = {{24{~r_isaretsiz & w_kayik[7]}},  w_kayik[7:0]};
      2'b01:   w_yuk_veri = {{16{~r_isaretsiz & w_kayik[15]}}, w_kayik[15:0]};
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_durum <= BOSTA;
    else       r_durum <= w_sonraki;
  end

  // Next-state logic
  always_comb begin
    w_sonraki = r_durum;
    case (r_durum)
      BOSTA:   if (w_kabul) w_sonraki = ISTEK;
      ISTEK:   if (bellek_hazir_i) w_sonraki = r_yaz ? BOSTA : BEKLE;
      BEKLE:   if (bellek_gecerli_i || w_sure_doldu) w_sonraki = BOSTA;
      default: w_sonraki = BOSTA;
    endcase
  end

  // Next values of the writeback and error pulses
  always_comb begin
    w_wb        = 1'b0;
    w_hiz_d     = 1'b0;
    w_za_d      = 1'b0;
    w_wb_veri   = amb_sonuc_i;
    w_wb_yazmac = hedef_yazmac_i;
    case (r_durum)
      BOSTA: begin
        if (amb_gecerli_i && !bellek_islem_i[3]) w_wb = (hedef_yazmac_i != 5'd0);
        w_hiz_d = w_hizasiz;
      end
      BEKLE: begin
        w_wb_veri   = w_yuk_veri;
        w_wb_yazmac = r_hedef;
        if (bellek_gecerli_i)  w_wb   = (r_hedef != 5'd0);
        else if (w_sure_doldu) w_za_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Wait-cycle counter, cleared whenever not waiting for load data
  always_ff @(posedge clk_i) begin
    if (rst_i)                 r_sayac <= '0;
    else if (r_durum != BEKLE) r_sayac <= '0;
    else                       r_sayac <= r_sayac + 1'b1;
  end

  // Request capture on acceptance; held stable until the memory takes it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_adres     <= '0;
      r_wveri     <= '0;
      r_maske     <= '0;
      r_ofs       <= '0;
      r_boyut     <= '0;
      r_yaz       <= 1'b0;
      r_isaretsiz <= 1'b0;
      r_hedef     <= '0;
    end else if (w_kabul) begin
      r_adres     <= {amb_sonuc_i[31:2], 2'b00};
      r_wveri     <= w_wveri;
      r_maske     <= w_maske;
      r_ofs       <= amb_sonuc_i[1:0];
      r_boyut     <= bellek_islem_i[1:0];
      r_yaz       <= bellek_islem_i[2];
      r_isaretsiz <= isaretsiz_i;
      r_hedef     <= hedef_yazmac_i;
    end
  end

  // Registered writeback/error outputs; data and index hold between pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gy_gecerli  <= 1'b0;
      r_gy_veri     <= '0;
      r_gy_yazmac   <= '0;
      r_hizasiz     <= 1'b0;
      r_zaman_asimi <= 1'b0;
    end else begin
      r_gy_gecerli  <= w_wb;
      r_hizasiz     <= w_hiz_d;
      r_zaman_asimi <= w_za_d;
      if (w_wb) begin
        r_gy_veri   <= w_wb_veri;
        r_gy_yazmac <= w_wb_yazmac;
      end
    end
  end

  assign bellek_istek_o = (r_durum == ISTEK);
  assign bellek_yaz_o   = r_yaz & bellek_istek_o;
  assign bellek_adres_o = r_adres;
  assign bellek_veri_o  = r_wveri;
  assign bellek_maske_o = r_maske;
  assign durdur_o       = (r_durum != BOSTA);
  assign gy_gecerli_o   = r_gy_gecerli;
  assign gy_veri_o      = r_gy_veri;
  assign gy_yazmac_o    = r_gy_yazmac;
  assign hizasiz_o      = r_hizasiz;
  assign zaman_asimi_o  = r_zaman_asimi;

endmodule

// File: tb/tb_bellek_erisim.sv
// Bench for bellek_erisim: single-cycle vector table, directed multi-cycle
// sequences and randomized transactions checked against an arithmetic model.
module tb_bellek_erisim;
  localparam int ZA = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        amb_gecerli_i;
  logic [31:0] amb_sonuc_i;
  logic [31:0] yazmac_degeri2_i;
  logic [3:0]  bellek_islem_i;
  logic        isaretsiz_i;
  logic [4:0]  hedef_yazmac_i;
  logic        bellek_istek_o, bellek_yaz_o;
  logic [31:0] bellek_adres_o, bellek_veri_o;
  logic [3:0]  bellek_maske_o;
  logic        bellek_hazir_i, bellek_gecerli_i;
  logic [31:0] bellek_veri_i;
  logic        gy_gecerli_o;
  logic [31:0] gy_veri_o;
  logic [4:0]  gy_yazmac_o;
  logic        durdur_o, hizasiz_o, zaman_asimi_o;

  bellek_erisim #(.ZAMAN_ASIMI(ZA)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .amb_gecerli_i(amb_gecerli_i), .amb_sonuc_i(amb_sonuc_i),
    .yazmac_degeri2_i(yazmac_degeri2_i), .bellek_islem_i(bellek_islem_i),
    .isaretsiz_i(isaretsiz_i), .hedef_yazmac_i(hedef_yazmac_i),
    .bellek_istek_o(bellek_istek_o), .bellek_yaz_o(bellek_yaz_o),
    .bellek_adres_o(bellek_adres_o), .bellek_veri_o(bellek_veri_o),
    .bellek_maske_o(bellek_maske_o), .bellek_hazir_i(bellek_hazir_i),
    .bellek_gecerli_i(bellek_gecerli_i), .bellek_veri_i(bellek_veri_i),
    .gy_gecerli_o(gy_gecerli_o), .gy_veri_o(gy_veri_o), .gy_yazmac_o(gy_yazmac_o),
    .durdur_o(durdur_o), .hizasiz_o(hizasiz_o), .zaman_asimi_o(zaman_asimi_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_test = 0;
  int          n_fail = 0;
  logic [31:0] m_last;     // last written-back value, expected to hold between pulses
  logic        m_last_ok;  // previous operation produced a writeback

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_test++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---- reference model: plain arithmetic on the request fields ----
  function automatic logic [3:0] m_maske(input logic [1:0] sz, input logic [1:0] ofs);
    if (sz == 2'd0) return 4'(1 << ofs);
    if (sz == 2'd1) return 4'(3 << ofs);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] rs2);
    if (sz == 2'd0) return (rs2 % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (rs2 % 65536) * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] ofs,
                                         input logic uns, input logic [31:0] w);
    logic [31:0] v;
    if (sz == 2'd2) return w;
    v = w >> (8 * ofs);
    if (sz == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Drive one op in the idle state for one cycle, then deassert.
  task automatic issue(input logic [3:0] islem, input logic [31:0] a, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic uns);
    amb_gecerli_i = 1'b1; bellek_islem_i = islem; amb_sonuc_i = a;
    yazmac_degeri2_i = rs2; hedef_yazmac_i = rd; isaretsiz_i = uns;
    step();
  endtask

  // One cycle of idle inputs, then check every pulse is gone and data held.
  task automatic idle_check();
    amb_gecerli_i = 1'b0; bellek_hazir_i = 1'b0; bellek_gecerli_i = 1'b0;
    step();
    chk("gy_pulse", gy_gecerli_o, 0);
    chk("hiz_pulse", hizasiz_o, 0);
    chk("za_pulse", zaman_asimi_o, 0);
    chk("istek_idle", bellek_istek_o, 0);
    chk("durdur_idle", durdur_o, 0);
    if (m_last_ok) chk("gy_hold", gy_veri_o, m_last);
  endtask

  // Full aligned memory transaction. hz = cycles before hazir, g = empty wait
  // cycles before read data (g >= ZA means the data never comes in time).
  task automatic do_tx(input logic st, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] rs2, input logic [4:0] rd, input logic uns,
                       input int hz, input int g, input logic [31:0] word);
    logic done;
    issue({1'b1, st, sz}, a, rs2, rd, uns);
    m_last_ok = 1'b0;
    chk("istek", bellek_istek_o, 1);
    chk("adres", bellek_adres_o, {a[31:2], 2'b00});
    chk("maske", {28'd0, bellek_maske_o}, {28'd0, m_maske(sz, a[1:0])});
    chk("wveri", bellek_veri_o, st ? m_wdata(sz, rs2) : 32'd0);
    chk("yaz", bellek_yaz_o, st);
    chk("durdur", durdur_o, 1);
    // upstream junk while stalled must be ignored
    amb_gecerli_i = 1'b1; bellek_islem_i = 4'b0000; hedef_yazmac_i = 5'd7;
    amb_sonuc_i = $urandom;
    for (int i = 0; i < hz; i++) begin
      bellek_gecerli_i = 1'($urandom_range(0, 1));
      bellek_veri_i = $urandom;
      step();
      chk("istek_hold", bellek_istek_o, 1);
      chk("adres_hold", bellek_adres_o, {a[31:2], 2'b00});
      chk("gy_in_istek", gy_gecerli_o, 0);
    end
    bellek_gecerli_i = 1'b0; bellek_hazir_i = 1'b1;
    step();
    bellek_hazir_i = 1'b0;
    chk("istek_drop", bellek_istek_o, 0);
    chk("gy_after_hazir", gy_gecerli_o, 0);
    if (st) begin
      chk("durdur_store", durdur_o, 0);
    end else begin
      chk("durdur_wait", durdur_o, 1);
      done = 1'b0;
      for (int k = 1; k <= ZA && !done; k++) begin
        if (k == g + 1) begin
          bellek_gecerli_i = 1'b1; bellek_veri_i = word;
          step();
          bellek_gecerli_i = 1'b0;
          chk("ld_gy", gy_gecerli_o, rd != 5'd0);
          if (rd != 5'd0) begin
            chk("ld_veri", gy_veri_o, m_load(sz, a[1:0], uns, word));
            chk("ld_rd", gy_yazmac_o, rd);
            m_last = m_load(sz, a[1:0], uns, word);
            m_last_ok = 1'b1;
          end
          chk("ld_no_za", zaman_asimi_o, 0);
          chk("ld_durdur", durdur_o, 0);
          done = 1'b1;
        end else begin
          bellek_gecerli_i = 1'b0; bellek_veri_i = $urandom;
          step();
          if (k == ZA) begin
            chk("za_pulse_on", zaman_asimi_o, 1);
            chk("za_durdur", durdur_o, 0);
            chk("za_no_gy", gy_gecerli_o, 0);
          end else begin
            chk("wait_no_za", zaman_asimi_o, 0);
            chk("wait_durdur", durdur_o, 1);
          end
        end
      end
    end
    amb_gecerli_i = 1'b0;
  endtask

  typedef struct {
    logic        vld;
    logic [3:0]  islem;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic        ewb;
    logic [31:0] everi;
    logic        ehiz;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 4'b0000, 32'h0000_1234, 5'd5,  1'b1, 32'h0000_1234, 1'b0};
    tbl[1]  = '{1'b1, 4'b0000, 32'hDEAD_BEEF, 5'd0,  1'b0, 32'h0,         1'b0};
    tbl[2]  = '{1'b1, 4'b0000, 32'hFFFF_FFFF, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0};
    tbl[3]  = '{1'b1, 4'b1010, 32'h0000_3001, 5'd4,  1'b0, 32'h0,         1'b1};
    tbl[4]  = '{1'b1, 4'b1001, 32'h0000_2001, 5'd4,  1'b0, 32'h0,         1'b1};
    tbl[5]  = '{1'b1, 4'b1110, 32'h0000_4002, 5'd4,  1'b0, 32'h0,         1'b1};
    tbl[6]  = '{1'b1, 4'b1101, 32'h0000_4003, 5'd4,  1'b0, 32'h0,         1'b1};
    tbl[7]  = '{1'b1, 4'b1011, 32'h0000_5000, 5'd4,  1'b0, 32'h0,         1'b1};
    tbl[8]  = '{1'b1, 4'b1111, 32'h0000_5000, 5'd4,  1'b0, 32'h0,         1'b1};
    tbl[9]  = '{1'b0, 4'b0000, 32'h0000_0042, 5'd3,  1'b0, 32'h0,         1'b0};
    tbl[10] = '{1'b0, 4'b1010, 32'h0000_3001, 5'd3,  1'b0, 32'h0,         1'b0};

    m_last = '0; m_last_ok = 1'b0;
    rst_i = 1'b1; amb_gecerli_i = 1'b0; amb_sonuc_i = '0; yazmac_degeri2_i = '0;
    bellek_islem_i = '0; isaretsiz_i = 1'b0; hedef_yazmac_i = '0;
    bellek_hazir_i = 1'b0; bellek_gecerli_i = 1'b0; bellek_veri_i = '0;
    step(); step();
    chk("rst_istek", bellek_istek_o, 0);
    chk("rst_adres", bellek_adres_o, 0);
    chk("rst_maske", {28'd0, bellek_maske_o}, 0);
    chk("rst_gy", gy_gecerli_o, 0);
    chk("rst_gy_veri", gy_veri_o, 0);
    chk("rst_durdur", durdur_o, 0);
    rst_i = 1'b0;

    // single-cycle vectors: ALU results and misaligned/reserved memory ops
    foreach (tbl[i]) begin
      amb_gecerli_i = tbl[i].vld; bellek_islem_i = tbl[i].islem; amb_sonuc_i = tbl[i].addr;
      hedef_yazmac_i = tbl[i].rd; yazmac_degeri2_i = 32'hAAAA_5555; isaretsiz_i = 1'b0;
      step();
      chk($sformatf("v%0d_gy", i), gy_gecerli_o, tbl[i].ewb);
      if (tbl[i].ewb) begin
        chk($sformatf("v%0d_veri", i), gy_veri_o, tbl[i].everi);
        chk($sformatf("v%0d_rd", i), gy_yazmac_o, tbl[i].rd);
        m_last = tbl[i].everi;
      end
      m_last_ok = tbl[i].ewb;
      chk($sformatf("v%0d_hiz", i), hizasiz_o, tbl[i].ehiz);
      chk($sformatf("v%0d_istek", i), bellek_istek_o, 0);
      chk($sformatf("v%0d_durdur", i), durdur_o, 0);
      idle_check();
    end

    // SB 0x1003 with hazir after 2 cycles
    do_tx(1'b1, 2'd0, 32'h0000_1003, 32'hAABB_CCDD, 5'd9, 1'b0, 2, 0, 32'h0);
    idle_check();
    // LH signed / unsigned from upper half
    do_tx(1'b0, 2'd1, 32'h0000_2002, 32'h0, 5'd6, 1'b0, 1, 2, 32'h8001_7FFF);
    idle_check();
    do_tx(1'b0, 2'd1, 32'h0000_2002, 32'h0, 5'd6, 1'b1, 0, 0, 32'h8001_7FFF);
    idle_check();
    // LW timeout, then data arriving in the very last wait cycle
    do_tx(1'b0, 2'd2, 32'h0000_3000, 32'h0, 5'd8, 1'b0, 0, ZA, 32'h1111_2222);
    idle_check();
    do_tx(1'b0, 2'd2, 32'h0000_3004, 32'h0, 5'd8, 1'b0, 0, ZA - 1, 32'h3333_4444);
    idle_check();
    // load to x0 never writes back
    do_tx(1'b0, 2'd0, 32'h0000_3007, 32'h0, 5'd0, 1'b0, 0, 1, 32'hFF00_0000);
    idle_check();

    // reset while waiting for load data
    issue(4'b1010, 32'h0000_6000, 32'h0, 5'd12, 1'b0);
    amb_gecerli_i = 1'b0; bellek_hazir_i = 1'b1;
    step();
    bellek_hazir_i = 1'b0;
    step(); step();
    chk("pre_rst_durdur", durdur_o, 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mrst_istek", bellek_istek_o, 0);
    chk("mrst_yaz", bellek_yaz_o, 0);
    chk("mrst_adres", bellek_adres_o, 0);
    chk("mrst_wveri", bellek_veri_o, 0);
    chk("mrst_maske", {28'd0, bellek_maske_o}, 0);
    chk("mrst_gy", gy_gecerli_o, 0);
    chk("mrst_gy_veri", gy_veri_o, 0);
    chk("mrst_gy_rd", gy_yazmac_o, 0);
    chk("mrst_durdur", durdur_o, 0);
    chk("mrst_hiz", hizasiz_o, 0);
    chk("mrst_za", zaman_asimi_o, 0);
    bellek_gecerli_i = 1'b1; bellek_veri_i = 32'hCAFE_F00D;
    step();
    bellek_gecerli_i = 1'b0;
    chk("late_gecerli_gy", gy_gecerli_o, 0);
    chk("late_gecerli_durdur", durdur_o, 0);
    m_last = '0; m_last_ok = 1'b0;

    // randomized mix against the model
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  sz;
      logic [31:0] a, rs2, w;
      logic [4:0]  rd;
      int          r, g;
      sz = 2'($urandom_range(0, 2));
      a = $urandom; rs2 = $urandom; w = $urandom; rd = 5'($urandom);
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz == 2'd2) a[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      g = (r < 8) ? r : ((r == 8) ? ZA - 1 : ZA);
      if ($urandom_range(0, 3) == 0) begin
        issue(4'b0000, a, rs2, rd, 1'b0);
        chk("rnd_alu_gy", gy_gecerli_o, rd != 5'd0);
        if (rd != 5'd0) begin
          chk("rnd_alu_veri", gy_veri_o, a);
          chk("rnd_alu_rd", gy_yazmac_o, rd);
          m_last = a;
        end
        m_last_ok = (rd != 5'd0);
      end else begin
        do_tx(1'($urandom_range(0, 1)), sz, a, rs2, rd, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), g, w);
      end
      idle_check();
    end

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end
endmodule
